alu_op_sequencer: RTL

- Sequences the 4-bit ALU. Operand A comes from the SPI slave, operand B from the photoresistor decoder code, and the operation from the four op buttons (M, S, N, X).
- Debounces the buttons and turns presses into single-shot operation requests. Issues each request to the ALU, waits a settle window, then captures result and flags into registers for LEDs and display.
- Sits between the SPI slave, the photoresistor decoder, the button pins and the ALU in the top-level FPGA controller.

---
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Button-driven operation sequencer for the 4-bit ALU: debounce, issue, settle, capture.
// Optional build macro ALU_OPSEQ_REPEAT_EN: an SPI operand update in IDLE re-issues the last op.
module alu_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic       FPGA_clk,
  input  logic       FPGA_reset,
  input  logic [3:0] spi_data_in,
  input  logic       spi_data_valid,
  input  logic [1:0] sensor_code,
  input  logic [3:0] op_buttons,
  input  logic [7:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  output logic       busy,
  output logic       result_valid,
  output logic [7:0] result_out,
  output logic [3:0] flags_out,
  output logic       op_error
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, CAPTURE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      btn_sync_p0, btn_sync_p1;
  logic [3:0]      btn_acc, btn_acc_d;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      press;
  logic [3:0]      a_shadow, a_issue;
  logic [3:0]      settle_cnt;
  logic            one_press, multi_press, repeat_req, start;

  function automatic logic [1:0] press_to_sel(input logic [3:0] p);
    if (p[1])      return 2'd1;
    else if (p[2]) return 2'd2;
    else if (p[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  // Stage p0/p1: two-flop synchronizer on the raw button pins
  always_ff @(posedge FPGA_clk or negedge FPGA_reset) begin
    if (!FPGA_reset) begin
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
    end else begin
      btn_sync_p0 <= op_buttons;
      btn_sync_p1 <= btn_sync_p0;
    end
  end

  // Debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge FPGA_clk or negedge FPGA_reset) begin
    if (!FPGA_reset) begin
      btn_acc   <= '0;
      btn_acc_d <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_acc_d <= btn_acc;
      for (int i = 0; i < 4; i++) begin
        if (btn_sync_p1[i] == btn_acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          btn_acc[i] <= btn_sync_p1[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press       = btn_acc & ~btn_acc_d;
  assign one_press   = (press != 4'b0) && ((press & (press - 4'd1)) == 4'b0);
  assign multi_press = (press != 4'b0) && !one_press;

`ifdef ALU_OPSEQ_REPEAT_EN
  logic done_once;

  always_ff @(posedge FPGA_clk or negedge FPGA_reset) begin
    if (!FPGA_reset)           done_once <= 1'b0;
    else if (state == CAPTURE) done_once <= 1'b1;
  end

  // A fresh SPI word bypasses the shadow so a same-cycle start uses the new operand
  assign repeat_req = done_once && spi_data_valid && (press == 4'b0);
  assign a_issue    = spi_data_valid ? spi_data_in : a_shadow;
`else
  assign repeat_req = 1'b0;
  assign a_issue    = a_shadow;
`endif

  always_ff @(posedge FPGA_clk or negedge FPGA_reset) begin
    if (!FPGA_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    op_error     = 1'b0;
    start        = 1'b0;
    case (state)
      IDLE: begin
        if (one_press) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end else if (multi_press) begin
          op_error = 1'b1;
        end else if (repeat_req) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result registers; capture happens on the edge entering CAPTURE so the
  // captured values are already on result_out/flags_out during the result_valid cycle
  always_ff @(posedge FPGA_clk or negedge FPGA_reset) begin
    if (!FPGA_reset) begin
      a_shadow   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      settle_cnt <= '0;
      result_out <= '0;
      flags_out  <= '0;
    end else begin
      if (spi_data_valid) a_shadow <= spi_data_in;
      if (start) begin
        alu_a <= a_issue;
        alu_b <= {2'b00, sensor_code};
        if (one_press) alu_sel <= press_to_sel(press);
      end
      if (state == ISSUE) begin
        settle_cnt <= SETTLE_INIT;
      end else if (state == SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (state == SETTLE && settle_cnt == 4'd0) begin
        result_out <= alu_result;
        flags_out  <= alu_flags;
      end
    end
  end

endmodule
